tube_scan_ctrl: RTL and testbench

- Sequential controller for the 8-digit seven-segment tube bank.
- Accepts a 21-bit binary value on a load strobe and converts it to eight BCD digits over 21 cycles using an iterative shift-add-3 sequencer, not a combinational divider.
- Commits the digits to a display register and time-multiplexes them onto one shared segment bus with a one-hot digit select.
- Sits between the arithmetic/result logic and the board tube pins.

---
 rtl/tube_scan_ctrl_pkg.sv | 40 ++++
 rtl/bcd_seg_lut.sv | 27 ++
 rtl/tube_scan_ctrl.sv | 149 ++++++++++++++
 tb/tb_tube_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tube_scan_ctrl_pkg.sv
// tube_scan_ctrl_pkg: shared constants for the tube bank controller.
// Holds segment encodings, converter sizing, FSM states and the BCD adjust helper.
package tube_scan_ctrl_pkg;

    localparam int unsigned TUBE_BITS   = 8;
    localparam int unsigned TSC_IN_BITS = 21;
    localparam int unsigned TSC_DIGITS  = 8;

    // Segment patterns, bit order {dp,g,f,e,d,c,b,a}, active-high
    localparam logic [TUBE_BITS-1:0] SEG_ZERO  = 8'h3F;
    localparam logic [TUBE_BITS-1:0] SEG_ONE   = 8'h06;
    localparam logic [TUBE_BITS-1:0] SEG_TWO   = 8'h5B;
    localparam logic [TUBE_BITS-1:0] SEG_THREE = 8'h4F;
    localparam logic [TUBE_BITS-1:0] SEG_FOUR  = 8'h66;
    localparam logic [TUBE_BITS-1:0] SEG_FIVE  = 8'h6D;
    localparam logic [TUBE_BITS-1:0] SEG_SIX   = 8'h7D;
    localparam logic [TUBE_BITS-1:0] SEG_SEVEN = 8'h07;
    localparam logic [TUBE_BITS-1:0] SEG_EIGHT = 8'h7F;
    localparam logic [TUBE_BITS-1:0] SEG_NINE  = 8'h6F;
    localparam logic [TUBE_BITS-1:0] SEG_EMP   = 8'h00;

    typedef enum logic [1:0] {
        TSC_IDLE   = 2'd0,
        TSC_CONV   = 2'd1,
        TSC_COMMIT = 2'd2
    } tsc_state_t;

    // Shift-add-3 correction: every nibble >= 5 gets +3 before the next shift
    function automatic logic [4*TSC_DIGITS-1:0] bcd_add3(input logic [4*TSC_DIGITS-1:0] bcd);
        logic [4*TSC_DIGITS-1:0] res;
        res = bcd;
        for (int unsigned k = 0; k < TSC_DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                res[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_seg_lut.sv
// bcd_seg_lut: one BCD digit to a tube segment pattern; codes 10..15 blank the tube.
module bcd_seg_lut
    import tube_scan_ctrl_pkg::*;
(
    input  logic [3:0]           i_digit,
    output logic [TUBE_BITS-1:0] o_seg
);

    // Digit decode; anything outside 0..9 (including the blank code) is dark
    always_comb begin
        o_seg = SEG_EMP;
        case (i_digit)
            4'd0:    o_seg = SEG_ZERO;
            4'd1:    o_seg = SEG_ONE;
            4'd2:    o_seg = SEG_TWO;
            4'd3:    o_seg = SEG_THREE;
            4'd4:    o_seg = SEG_FOUR;
            4'd5:    o_seg = SEG_FIVE;
            4'd6:    o_seg = SEG_SIX;
            4'd7:    o_seg = SEG_SEVEN;
            4'd8:    o_seg = SEG_EIGHT;
            4'd9:    o_seg = SEG_NINE;
            default: o_seg = SEG_EMP;
        endcase
    end

endmodule

// File: rtl/tube_scan_ctrl.sv
// tube_scan_ctrl: binary-to-BCD sequencer plus 8-digit multiplexed tube scanner.
// Optional leading-zero blanking is enabled by defining TUBE_LZB_EN.
module tube_scan_ctrl
    import tube_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [TSC_IN_BITS-1:0] value,
    input  logic                   load,
    output logic                   busy,
    output logic                   done,
    output logic [TSC_DIGITS-1:0]  tube_sel,
    output logic [TUBE_BITS-1:0]   tube_seg
);

    localparam int unsigned CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [4:0]  BIT_LAST = 5'(TSC_IN_BITS - 1);
`ifdef TUBE_LZB_EN
    localparam logic [TSC_DIGITS-1:0] MASK_RST = 8'hFE;
`else
    localparam logic [TSC_DIGITS-1:0] MASK_RST = '0;
`endif

    tsc_state_t                  r_state;
    tsc_state_t                  w_next_state;
    logic                        w_busy;
    logic [TSC_IN_BITS-1:0]      r_shift;
    logic [4*TSC_DIGITS-1:0]     r_bcd;
    logic [4*TSC_DIGITS-1:0]     w_bcd_adj;
    logic [4:0]                  r_bitcnt;
    logic [4*TSC_DIGITS-1:0]     r_disp;
    logic [TSC_DIGITS-1:0]       r_mask;
    logic [TSC_DIGITS-1:0]       w_mask_new;
    logic                        r_done;
    logic [CNT_W-1:0]            r_scan_cnt;
    logic [2:0]                  r_idx;
    logic [TSC_DIGITS-1:0]       r_tube_sel;
    logic [TUBE_BITS-1:0]        r_tube_seg;
    logic [3:0]                  w_digit;
    logic [TUBE_BITS-1:0]        w_seg;

    assign w_bcd_adj = bcd_add3(r_bcd);

    // Converter state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= TSC_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and busy flag
    always_comb begin
        w_next_state = r_state;
        w_busy       = (r_state != TSC_IDLE);
        case (r_state)
            TSC_IDLE:   if (load) w_next_state = TSC_CONV;
            TSC_CONV:   if (r_bitcnt == BIT_LAST) w_next_state = TSC_COMMIT;
            TSC_COMMIT: w_next_state = TSC_IDLE;
            default:    w_next_state = TSC_IDLE;
        endcase
    end

`ifdef TUBE_LZB_EN
    logic w_lead;

    // Blank digit k (k>=1) when it and every higher digit are zero
    always_comb begin
        w_mask_new = '0;
        w_lead     = 1'b1;
        for (int unsigned k = TSC_DIGITS - 1; k >= 1; k--) begin
            w_lead        = w_lead && (r_bcd[4*k +: 4] == 4'd0);
            w_mask_new[k] = w_lead;
        end
    end
`else
    assign w_mask_new = '0;
`endif

    // Converter datapath: capture, shift-add-3 iterations, commit to display
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_bcd    <= '0;
            r_bitcnt <= '0;
            r_disp   <= '0;
            r_mask   <= MASK_RST;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                TSC_IDLE: begin
                    if (load) begin
                        r_shift  <= value;
                        r_bcd    <= '0;
                        r_bitcnt <= '0;
                    end
                end
                TSC_CONV: begin
                    r_bcd    <= {w_bcd_adj[4*TSC_DIGITS-2:0], r_shift[TSC_IN_BITS-1]};
                    r_shift  <= {r_shift[TSC_IN_BITS-2:0], 1'b0};
                    r_bitcnt <= r_bitcnt + 5'd1;
                end
                TSC_COMMIT: begin
                    r_disp <= r_bcd;
                    r_mask <= w_mask_new;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Blanked digits are routed to the LUT as a non-decimal code so it emits the blank pattern
    assign w_digit = r_mask[r_idx] ? 4'hF : r_disp[{r_idx, 2'b00} +: 4];

    bcd_seg_lut u_seg_lut (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    // Scanner: slot counter, digit index and registered tube outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_tube_sel <= '0;
            r_tube_seg <= SEG_EMP;
        end else begin
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 3'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            r_tube_sel <= TSC_DIGITS'(1) << r_idx;
            r_tube_seg <= w_seg;
        end
    end

    assign busy     = w_busy;
    assign done     = r_done;
    assign tube_sel = r_tube_sel;
    assign tube_seg = r_tube_seg;

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb_tube_scan_ctrl: randomized and directed checks of tube_scan_ctrl against a
// cycle-level reference model (decimal arithmetic, countdown converter timing).
// Honours TUBE_LZB_EN the same way as the design.
`timescale 1ns/1ps
module tb_tube_scan_ctrl;

    localparam int unsigned SD = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic [20:0] value = '0;
    logic        busy, done;
    logic [7:0]  tube_sel;
    logic [7:0]  tube_seg;

    int n_checks = 0;
    int n_pass   = 0;

    tube_scan_ctrl #(.SCAN_DIV(SD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .busy     (busy),
        .done     (done),
        .tube_sel (tube_sel),
        .tube_seg (tube_seg)
    );

    always #5 clk = ~clk;

    // Reference segment table
    function automatic logic [7:0] enc(input int unsigned d);
        case (d)
            0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
            4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
            8: return 8'h7F;  9: return 8'h6F;
            default: return 8'h00;
        endcase
    endfunction

    // Expected pattern of decimal digit k of v, with optional leading-zero blanking
    function automatic logic [7:0] seg_of(input int unsigned v, input int unsigned k);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < k; i++) p = p * 10;
`ifdef TUBE_LZB_EN
        if (k != 0 && v < p) return 8'h00;
`endif
        return enc((v / p) % 10);
    endfunction

    // Reference model: edges since reset release drive the scan, a countdown models conversion
    int unsigned m_edges = 0;
    int unsigned m_left  = 0;
    int unsigned m_val   = 0;
    int unsigned m_disp  = 0;
    logic        exp_done = 1'b0;
    logic [7:0]  exp_sel  = 8'h00;
    logic [7:0]  exp_seg  = 8'h00;
    logic        exp_busy;
    assign exp_busy = (m_left != 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            m_edges  <= 0;
            m_left   <= 0;
            m_disp   <= 0;
            exp_done <= 1'b0;
            exp_sel  <= 8'h00;
            exp_seg  <= 8'h00;
        end else begin
            m_edges  <= m_edges + 1;
            exp_sel  <= 8'(1 << ((m_edges / SD) % 8));
            exp_seg  <= seg_of(m_disp, (m_edges / SD) % 8);
            exp_done <= 1'b0;
            if (m_left == 0) begin
                if (load) begin
                    m_val  <= {11'b0, value};
                    m_left <= 22;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_disp   <= m_val;
                    exp_done <= 1'b1;
                end
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, tube_sel, tube_seg} !== 18'h0) begin
            $display("FAIL reset_values busy/done/sel/seg=%b/%b/%h/%h required 0/0/00/00", busy, done, tube_sel, tube_seg);
        end else n_pass++;
        rst_n = 1'b1;
        for (int c = 1; c <= int'(SD * 8 + SD + 2); c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_checks++;
                if (tube_sel !== 8'h01) begin
                    $display("FAIL first_sel actual=%h required=01", tube_sel);
                end else n_pass++;
            end
            n_checks++;
            if ({busy, done, tube_sel, tube_seg} !== {exp_busy, exp_done, exp_sel, exp_seg}) begin
                $display("FAIL reset_scan c=%0d busy/done/sel/seg=%b/%b/%h/%h required %b/%b/%h/%h",
                         c, busy, done, tube_sel, tube_seg, exp_busy, exp_done, exp_sel, exp_seg);
            end else n_pass++;
        end
    endtask

    task automatic test_conv(input int unsigned v);
        int lat;
        lat   = -1;
        value = 21'(v);
        load  = 1'b1;
        for (int c = 1; c <= int'(23 + SD * 8 + 2); c++) begin
            @(negedge clk);
            if (done === 1'b1 && lat < 0) lat = c - 1;
            n_checks++;
            if ({busy, done, tube_sel, tube_seg} !== {exp_busy, exp_done, exp_sel, exp_seg}) begin
                $display("FAIL conv_%0d c=%0d busy/done/sel/seg=%b/%b/%h/%h required %b/%b/%h/%h",
                         v, c, busy, done, tube_sel, tube_seg, exp_busy, exp_done, exp_sel, exp_seg);
            end else n_pass++;
            if (c == 1) load = 1'b0;
        end
        n_checks++;
        if (lat !== 22) begin
            $display("FAIL latency_%0d actual=%0d required=22", v, lat);
        end else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int ndone;
        ndone = 0;
        value = 21'd42;
        load  = 1'b1;
        for (int c = 1; c <= int'(23 + SD * 8 + 2); c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            n_checks++;
            if ({busy, done, tube_sel, tube_seg} !== {exp_busy, exp_done, exp_sel, exp_seg}) begin
                $display("FAIL busy_ignore c=%0d busy/done/sel/seg=%b/%b/%h/%h required %b/%b/%h/%h",
                         c, busy, done, tube_sel, tube_seg, exp_busy, exp_done, exp_sel, exp_seg);
            end else n_pass++;
            if (c == 1) load = 1'b0;
            if (c == 5) begin
                value = 21'd999;
                load  = 1'b1;
            end
            if (c == 6) load = 1'b0;
        end
        n_checks++;
        if (ndone !== 1) begin
            $display("FAIL busy_ignore_done_count actual=%0d required=1", ndone);
        end else n_pass++;
    endtask

    task automatic test_reset_abort();
        int ndone;
        ndone = 0;
        value = 21'd555555;
        load  = 1'b1;
        for (int c = 1; c <= int'(30 + SD * 8); c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            n_checks++;
            if ({busy, done, tube_sel, tube_seg} !== {exp_busy, exp_done, exp_sel, exp_seg}) begin
                $display("FAIL reset_abort c=%0d busy/done/sel/seg=%b/%b/%h/%h required %b/%b/%h/%h",
                         c, busy, done, tube_sel, tube_seg, exp_busy, exp_done, exp_sel, exp_seg);
            end else n_pass++;
            if (c == 1)  load  = 1'b0;
            if (c == 10) rst_n = 1'b0;
            if (c == 11) rst_n = 1'b1;
        end
        n_checks++;
        if (ndone !== 0) begin
            $display("FAIL reset_abort_done_count actual=%0d required=0", ndone);
        end else n_pass++;
        test_conv(7);
    endtask

    task automatic test_back_to_back();
        int ndone;
        ndone = 0;
        value = 21'($urandom_range(0, 2097151));
        load  = 1'b1;
        for (int c = 1; c <= int'(69 + SD * 8); c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                value = 21'($urandom_range(0, 2097151));
            end
            n_checks++;
            if ({busy, done, tube_sel, tube_seg} !== {exp_busy, exp_done, exp_sel, exp_seg}) begin
                $display("FAIL back_to_back c=%0d busy/done/sel/seg=%b/%b/%h/%h required %b/%b/%h/%h",
                         c, busy, done, tube_sel, tube_seg, exp_busy, exp_done, exp_sel, exp_seg);
            end else n_pass++;
            if (c == 68) load = 1'b0;
        end
        n_checks++;
        if (ndone !== 3) begin
            $display("FAIL back_to_back_done_count actual=%0d required=3", ndone);
        end else n_pass++;
    endtask

    task automatic test_random();
        int unsigned pick;
        for (int c = 1; c <= 450; c++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, done, tube_sel, tube_seg} !== {exp_busy, exp_done, exp_sel, exp_seg}) begin
                $display("FAIL random c=%0d busy/done/sel/seg=%b/%b/%h/%h required %b/%b/%h/%h",
                         c, busy, done, tube_sel, tube_seg, exp_busy, exp_done, exp_sel, exp_seg);
            end else n_pass++;
            if (c > 420) begin
                load = 1'b0;
            end else if (load) begin
                if ($urandom_range(0, 2) == 0) load = 1'b0;
            end else if (done === 1'b1 || $urandom_range(0, 7) == 0) begin
                pick = $urandom_range(0, 5);
                case (pick)
                    0:       value = 21'd0;
                    1:       value = 21'd2097151;
                    2:       value = 21'd10;
                    3:       value = 21'd99999;
                    default: value = 21'($urandom_range(0, 2097151));
                endcase
                load = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_conv(1234567);
        test_conv(2097151);
        test_conv(0);
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
